// File: rtl/ddr_arbiter.sv
// ddr_arbiter: round-robin arbiter that shares one DDR command port among
// NUM_CLIENTS clients. Grants are made only in IDLE and are held for a whole
// burst (read beats returned, or write beats accepted).
//
// Ports (per-client signals are packed, client n in slice n):
//   clock, reset            single clock, synchronous active-high reset
//   io_in_rd/wr[n]          client burst read / per-beat write request
//   io_in_addr[n]           byte address (first beat only), 32 bits each
//   io_in_burstLength[n]    beats per burst (0 behaves as 1), 8 bits each
//   io_in_mask[n]           write byte enables, 8 bits each
//   io_in_din[n]            write data, 64 bits each
//   io_in_waitReq[n]        client stall
//   io_in_valid[n]          read data beat valid
//   io_in_dout[n]           read data, a copy of io_out_dout for every client
//   io_in_burstDone[n]      one-cycle pulse on the last beat of a burst
//   io_out_*                DDR-side command / data / handshake
module ddr_arbiter #(
    parameter int unsigned NUM_CLIENTS = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_CLIENTS-1:0]    io_in_rd,
    input  logic [NUM_CLIENTS-1:0]    io_in_wr,
    input  logic [NUM_CLIENTS*32-1:0] io_in_addr,
    input  logic [NUM_CLIENTS*8-1:0]  io_in_burstLength,
    input  logic [NUM_CLIENTS*8-1:0]  io_in_mask,
    input  logic [NUM_CLIENTS*64-1:0] io_in_din,
    output logic [NUM_CLIENTS-1:0]    io_in_waitReq,
    output logic [NUM_CLIENTS-1:0]    io_in_valid,
    output logic [NUM_CLIENTS*64-1:0] io_in_dout,
    output logic [NUM_CLIENTS-1:0]    io_in_burstDone,
    output logic                      io_out_rd,
    output logic                      io_out_wr,
    output logic [31:0]               io_out_addr,
    output logic [7:0]                io_out_burstLength,
    output logic [7:0]                io_out_mask,
    output logic [63:0]               io_out_din,
    input  logic                      io_out_waitReq,
    input  logic                      io_out_valid,
    input  logic [63:0]               io_out_dout
);

    localparam int unsigned IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      len_q, len_d;
    logic [31:0]     addr_q, addr_d;

    logic [NUM_CLIENTS-1:0] req;
    logic                   found;
    logic [IW-1:0]          win;
    int unsigned            cand;

    logic [IW-1:0]          act;
    logic                   act_en;
    logic [NUM_CLIENTS-1:0] act_oh;
    logic                   a_rd, a_wr;
    logic [31:0]            a_addr;
    logic [7:0]             a_len, a_mask, eff_len;
    logic [63:0]            a_din;

    assign io_in_dout = {NUM_CLIENTS{io_out_dout}};

    // Cyclic search starting one past the last granted client.
    always_comb begin
        req   = io_in_rd | io_in_wr;
        found = 1'b0;
        win   = '0;
        cand  = 0;
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            cand = 32'(ptr_q) + 32'd1 + i;
            if (cand >= NUM_CLIENTS) cand = cand - NUM_CLIENTS;
            for (int unsigned c = 0; c < NUM_CLIENTS; c++) begin
                if (!found && c == cand && req[c]) begin
                    found = 1'b1;
                    win   = IW'(c);
                end
            end
        end
    end

    // Active client: the search winner in IDLE, the latched grant mid-burst.
    always_comb begin
        act    = (state_q == IDLE) ? win : grant_q;
        act_en = (state_q != IDLE) || found;
        act_oh = '0;
        a_rd   = 1'b0;
        a_wr   = 1'b0;
        a_addr = '0;
        a_len  = '0;
        a_mask = '0;
        a_din  = '0;
        for (int unsigned c = 0; c < NUM_CLIENTS; c++) begin
            if (act_en && IW'(c) == act) begin
                act_oh[c] = 1'b1;
                a_rd      = io_in_rd[c];
                a_wr      = io_in_wr[c];
                a_addr    = io_in_addr[c*32 +: 32];
                a_len     = io_in_burstLength[c*8 +: 8];
                a_mask    = io_in_mask[c*8 +: 8];
                a_din     = io_in_din[c*64 +: 64];
            end
        end
        eff_len = (a_len == 8'd0) ? 8'd1 : a_len;
    end

    always_comb begin
        state_d            = state_q;
        grant_d            = grant_q;
        ptr_d              = ptr_q;
        cnt_d              = cnt_q;
        len_d              = len_q;
        addr_d             = addr_q;
        io_out_rd          = 1'b0;
        io_out_wr          = 1'b0;
        io_out_addr        = a_addr;
        io_out_burstLength = a_len;
        io_out_mask        = a_mask;
        io_out_din         = a_din;
        io_in_waitReq      = ~act_oh | {NUM_CLIENTS{io_out_waitReq}};
        io_in_valid        = '0;
        io_in_burstDone    = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    io_out_rd = a_rd;
                    // rd and wr together: the read wins, the write stays stalled.
                    io_out_wr = a_wr & ~a_rd;
                    if (!io_out_waitReq) begin
                        ptr_d   = win;
                        grant_d = win;
                        len_d   = a_len;
                        addr_d  = a_addr;
                        if (a_rd) begin
                            state_d = READ;
                            cnt_d   = eff_len;
                        end else if (eff_len == 8'd1) begin
                            io_in_burstDone = act_oh;
                        end else begin
                            state_d = WRITE;
                            cnt_d   = eff_len - 8'd1;
                        end
                    end
                end
            end
            READ: begin
                io_out_addr        = addr_q;
                io_out_burstLength = len_q;
                if (io_out_valid) begin
                    io_in_valid = act_oh;
                    cnt_d       = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        io_in_burstDone = act_oh;
                        state_d         = IDLE;
                    end
                end
            end
            WRITE: begin
                io_out_wr          = a_wr;
                io_out_addr        = addr_q;
                io_out_burstLength = len_q;
                if (a_wr && !io_out_waitReq) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        io_in_burstDone = act_oh;
                        state_d         = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            io_out_rd       = 1'b0;
            io_out_wr       = 1'b0;
            io_in_waitReq   = '1;
            io_in_valid     = '0;
            io_in_burstDone = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= IW'(NUM_CLIENTS - 1);
            cnt_q   <= '0;
            len_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: doc/ddr_arbiter.md
DDR_ARBITER -- requirements
Module: ddr_arbiter

Interface
REQ-001 Parameter NUM_CLIENTS, default 3, number of requesting clients (indices 0..NUM_CLIENTS-1).
REQ-002 clock  in  1  single clock for all logic.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 io_in_n_rd  in  1  client n burst read request.
REQ-005 io_in_n_wr  in  1  client n write request, one per beat.
REQ-006 io_in_n_addr  in  32  client n byte address, valid with the first beat only.
REQ-007 io_in_n_burstLength  in  8  client n beats per burst.
REQ-008 io_in_n_mask  in  8  client n write byte enables.
REQ-009 io_in_n_din  in  64  client n write data.
REQ-010 io_in_n_waitReq  out  1  client n stall.
REQ-011 io_in_n_valid  out  1  client n read data beat valid.
REQ-012 io_in_n_dout  out  64  read data, shared by all clients.
REQ-013 io_in_n_burstDone  out  1  one-cycle pulse on the last beat of client n's burst.
REQ-014 io_out_rd, io_out_wr  out  1 each  DDR requests.
REQ-015 io_out_addr  out  32;  io_out_burstLength  out  8;  io_out_mask  out  8;  io_out_din  out  64.
REQ-016 io_out_waitReq  in  1;  io_out_valid  in  1;  io_out_dout  in  64.

Function
REQ-017 FSM states: IDLE, READ, WRITE.
REQ-018 IDLE: the grant goes to the first client with rd|wr, searching cyclically from (last granted + 1).
REQ-019 IDLE: the granted client's rd, wr, addr, burstLength, mask and din pass combinationally to io_out in the same cycle.
REQ-020 IDLE: all non-granted clients see waitReq=1.
REQ-021 Granted client waitReq = io_out_waitReq; every other client waitReq = 1 in all states.
REQ-022 A request is accepted when it is asserted and io_out_waitReq=0.
REQ-023 On acceptance, the arbiter latches the grant index and burst length and updates the round-robin pointer.
REQ-024 Effective burst length: burstLength=0 counts as 1.
REQ-025 Read accepted -> READ, beat counter = length.
REQ-026 READ: io_out_rd=0 and io_out_wr=0 (no new commands).
REQ-027 READ: each io_out_valid decrements the counter and asserts valid on the latched client only.
REQ-028 READ: the final beat pulses burstDone and returns to IDLE in the next cycle.
REQ-029 Write accepted with length 1: burstDone pulses that cycle and the FSM stays IDLE.
REQ-030 Write accepted with length >1: counter = length-1, next state WRITE.
REQ-031 WRITE: only the latched client's wr, mask and din are forwarded; addr and burstLength are held from the first beat.
REQ-032 WRITE: each accepted beat decrements the counter; the last beat pulses burstDone and returns to IDLE.
REQ-033 rd and wr asserted together by one client: treated as read; wr is stalled.
REQ-034 io_out_valid in IDLE or WRITE is discarded; no client valid is asserted.
REQ-035 A client deasserting its request mid-WRITE inserts idle cycles; the grant is held until the burst completes.
REQ-036 No grant change mid-burst; other requesters wait.
REQ-037 io_in_n_dout = io_out_dout for all n, unregistered.

Reset
REQ-038 Reset returns the FSM to IDLE, clears the counter, and sets the pointer to NUM_CLIENTS-1 so client 0 has first priority.
REQ-039 During reset, all io_out_rd/wr, valid and burstDone outputs are 0, and client waitReq is 1.
REQ-040 Reset mid-burst abandons the burst; subsequent stray valid beats are discarded per REQ-034.

Verification
REQ-041 Clients 0, 1 and 2 assert rd simultaneously with burst 4, waitReq=0 -> grants in order 0,1,2, each client receives exactly 4 valid pulses, and burstDone occurs on the 4th pulse.
REQ-042 Client 1 writes burst 3 while io_out_waitReq is high for 2 cycles on beat 2 -> 3 beats reach the DDR in order, addr is held, and burstDone pulses on beat 3.
REQ-043 Client 0 rd with burstLength=0 -> io_out_burstLength=0 is forwarded, 1 valid beat is routed, and the FSM is back in IDLE in the next cycle.
REQ-044 Client 2 asserts rd&wr together -> a read is issued and io_out_wr stays 0.
REQ-045 Reset asserted after 2 of 8 read beats -> IDLE next cycle, the remaining 6 valid beats are dropped, and a following request from client 0 wins over client 1.
REQ-046 Client 0 writes burst 1 back-to-back while client 1 rd is pending -> client 1 is granted after a single client-0 beat, with no starvation.
